// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MD_MADD_EN.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0] cnt_q;
    logic [31:0]     hi_q, lo_q;
    logic [63:0]     pend_q;
    logic            pend_wr_q;

    logic is_mul, is_div, is_mthi, is_mtlo, op_signed;
`ifdef MD_MADD_EN
    logic is_acc, is_sub;
`endif

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        op_signed = 1'b0;
`ifdef MD_MADD_EN
        is_acc    = 1'b0;
        is_sub    = 1'b0;
`endif
        case (op)
            4'd1: begin is_mul = 1'b1; op_signed = 1'b1; end
            4'd2: is_mul = 1'b1;
            4'd3: begin is_div = 1'b1; op_signed = 1'b1; end
            4'd4: is_div = 1'b1;
            4'd5: is_mthi = 1'b1;
            4'd6: is_mtlo = 1'b1;
`ifdef MD_MADD_EN
            4'd7:  begin is_mul = 1'b1; is_acc = 1'b1; op_signed = 1'b1; end
            4'd8:  begin is_mul = 1'b1; is_acc = 1'b1; end
            4'd9:  begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; op_signed = 1'b1; end
            4'd10: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // One 64x64 multiplier; sign extension selects signed vs unsigned product.
    logic [63:0] a_ext, b_ext, prod;
    assign a_ext = op_signed ? {{32{a[31]}}, a} : {32'd0, a};
    assign b_ext = op_signed ? {{32{b[31]}}, b} : {32'd0, b};
    assign prod  = a_ext * b_ext;

    // Signed divide via magnitudes: truncates toward zero, remainder follows dividend.
    // 0x80000000 / -1 falls out naturally as magnitude 2^31 reinterpreted.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    assign a_neg  = op_signed & a[31];
    assign b_neg  = op_signed & b[31];
    assign a_mag  = a_neg ? (32'd0 - a) : a;
    assign b_mag  = b_neg ? (32'd0 - b) : b;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    logic [63:0] res;
    always_comb begin
        res = prod;
        if (is_div) begin
            res = {rem, quot};
        end
`ifdef MD_MADD_EN
        else if (is_acc) begin
            res = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1) && pend_wr_q) begin
                {hi_q, lo_q} <= pend_q;
            end
        end else if (start) begin
            if (is_mul) begin
                cnt_q     <= CntW'(MULT_CYCLES);
                pend_q    <= res;
                pend_wr_q <= 1'b1;
            end else if (is_div) begin
                cnt_q     <= CntW'(DIV_CYCLES);
                pend_q    <= res;
                // Divide by zero still occupies the unit but leaves HI/LO alone.
                pend_wr_q <= (b != 32'd0);
            end else if (is_mthi) begin
                hi_q <= a;
            end else if (is_mtlo) begin
                lo_q <= a;
            end
        end
    end

    assign busy = (cnt_q != '0);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO per multi-cycle op,
// a monitor checks them (and busy length, and HI/LO hold) whenever busy falls.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] old_hi, old_lo, new_hi, new_lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles, check HI/LO hold while busy, compare on the falling edge of busy.
    int   bcnt = 0;
    bit   hold_ok = 1'b1;
    logic pb = 1'b0;
    logic rst_seen = 1'b1;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            bcnt++;
            if (sb.size() > 0 && (hi !== sb[0].old_hi || lo !== sb[0].old_lo)) hold_ok = 1'b0;
        end else if (pb === 1'b1) begin
            if (rst_seen !== 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.new_hi});
                    chk({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.new_lo});
                    chk({e.name, "_cycles"}, 64'(bcnt), 64'(e.cycles));
                    chk({e.name, "_hold"}, {63'd0, hold_ok}, 64'd1);
                end
            end
            bcnt = 0;
            hold_ok = 1'b1;
        end
        pb = busy;
        rst_seen = reset;
    end

    task automatic expect_done(input string name, input logic [31:0] nh, input logic [31:0] nl,
                               input int cyc);
        exp_t e;
        e.old_hi = m_hi; e.old_lo = m_lo; e.new_hi = nh; e.new_lo = nl;
        e.cycles = cyc; e.name = name;
        sb.push_back(e);
        m_hi = nh;
        m_lo = nl;
    endtask

    // Called at posedge+#1; drives one start cycle and returns at posedge+#1 after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) chk("wait_idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle_cycles(2);
        reset = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);

        expect_done("mult", 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        issue(4'd1, 32'hFFFFFFFF, 32'h2);
        chk("mult_busy_rise", {63'd0, busy}, 64'd1);
        wait_idle();

        expect_done("multu", 32'h1, 32'hFFFFFFFE, 5);
        issue(4'd2, 32'hFFFFFFFF, 32'h2);
        wait_idle();

        expect_done("mult_negneg", 32'h0, 32'hF, 5);
        issue(4'd1, 32'hFFFFFFFD, 32'hFFFFFFFB);
        wait_idle();

        expect_done("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(4'd3, 32'hFFFFFFF9, 32'h2);
        wait_idle();

        expect_done("div_7_m2", 32'h1, 32'hFFFFFFFD, 10);
        issue(4'd3, 32'h7, 32'hFFFFFFFE);
        wait_idle();

        issue(4'd6, 32'h1234, 32'h0);
        m_lo = 32'h1234;
        chk("mtlo_lo", {32'd0, lo}, 64'h1234);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);

        expect_done("divu_by0", m_hi, m_lo, 10);
        issue(4'd4, 32'h7, 32'h0);
        wait_idle();

        issue(4'd5, 32'hDEADBEEF, 32'h0);
        m_hi = 32'hDEADBEEF;
        chk("mthi_hi", {32'd0, hi}, 64'hDEADBEEF);
        chk("mthi_busy", {63'd0, busy}, 64'd0);

        // mult and mtlo issued mid-divide must be ignored.
        expect_done("div_ignore", 32'h2, 32'hE, 10);
        issue(4'd3, 32'd100, 32'd7);
        idle_cycles(2);
        issue(4'd1, 32'd3, 32'd5);
        issue(4'd6, 32'h0BAD, 32'h0);
        wait_idle();

        expect_done("div_ovf", 32'h0, 32'h80000000, 10);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();

        expect_done("divu", 32'h5, 32'h19999999, 10);
        issue(4'd4, 32'hFFFFFFFF, 32'd10);
        wait_idle();

        issue(4'd0, 32'h1, 32'h1);
        issue(4'd12, 32'h1, 32'h1);
        chk("noop_busy", {63'd0, busy}, 64'd0);
        chk("noop_hilo", {hi, lo}, {m_hi, m_lo});

`ifdef MD_MADD_EN
        issue(4'd5, 32'h0, 32'h0);
        issue(4'd6, 32'hFFFFFFFF, 32'h0);
        m_hi = 32'h0;
        m_lo = 32'hFFFFFFFF;
        expect_done("madd", 32'h1, 32'h0, 5);
        issue(4'd7, 32'h1, 32'h1);
        wait_idle();
        expect_done("msub", 32'h0, 32'hFFFFFFFF, 5);
        issue(4'd9, 32'h1, 32'h1);
        wait_idle();
`else
        issue(4'd7, 32'h1, 32'h1);
        chk("madd_off_busy", {63'd0, busy}, 64'd0);
        idle_cycles(6);
        chk("madd_off_hilo", {hi, lo}, {m_hi, m_lo});
`endif

        // Reset on the 3rd busy cycle of a mult discards it.
        issue(4'd1, 32'd2, 32'd3);
        idle_cycles(2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        idle_cycles(8);
        chk("abort_no_late_wb", {hi, lo}, 64'd0);
        chk("abort_busy_late", {63'd0, busy}, 64'd0);

        idle_cycles(2);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
